pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have the following parameters, one per line as name, default and meaning:
- DATA_WIDTH, 32, address and operand width.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded when a misalignment trap is acknowledged.
- ALIGN_C, 0, alignment mode: 0 requires 4-byte alignment, 1 requires 2-byte alignment.
- CNT_WIDTH, 32, width of the retired-jump counter.

REQ-002 The block SHALL have the following ports, one per line as name, direction, width and meaning; the design uses one clock, and reset is asynchronous and active-low:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- update_pc, in, 1, instruction-retire pulse.
- jump_type, in, 3, one of the `JUMP_* encodings from defines.v; any value not listed there means sequential.
- addr_offset, in, DATA_WIDTH, branch/JAL immediate.
- alu_result, in, DATA_WIDTH, JALR target, or branch condition in bit 0.
- redirect_valid, in, 1, external redirect request (interrupt/return).
- redirect_addr, in, DATA_WIDTH, redirect target.
- fetch_ready, in, 1, instruction memory accepts fetch_addr.
- trap_ack, in, 1, trap handler accepts the trap.
- pc_current, out, DATA_WIDTH, architectural PC.
- pc_plus_4, out, DATA_WIDTH, pc_current+4.
- fetch_valid, out, 1, fetch request.
- fetch_addr, out, DATA_WIDTH, equals pc_current.
- misalign_trap, out, 1, trap pending.
- trap_pc, out, DATA_WIDTH, faulting target.
- taken_count, out, CNT_WIDTH, number of accepted taken jumps.

Function
REQ-003 The FSM SHALL have exactly three states: FETCH, EXEC and TRAP.
REQ-004 In FETCH, fetch_valid SHALL be 1 and fetch_addr SHALL equal pc_current, held stable until fetch_ready; fetch_valid && fetch_ready SHALL move to EXEC on the next edge.
REQ-005 fetch_valid SHALL be 0 in EXEC and TRAP.
REQ-006 update_pc SHALL be ignored in FETCH and TRAP.
REQ-007 In EXEC, update_pc SHALL compute the target, with all sums modulo 2^DATA_WIDTH:
- pc+addr_offset for `JUMP_JAL, `JUMP_IF_0 with alu_result[0]=0, and `JUMP_IF_1 with alu_result[0]=1.
- {alu_result[DATA_WIDTH-1:1],1'b0} for `JUMP_JALR.
- 0 for `JUMP_ZERO.
- pc+4 otherwise.
REQ-008 The target SHALL be misaligned when target[1:0]!=0 with ALIGN_C=0, or target[0]!=0 with ALIGN_C=1.
REQ-009 An aligned target SHALL be loaded into pc_current on the same edge, and the FSM SHALL go to FETCH; the new fetch_addr SHALL be visible one cycle after the update_pc edge.
REQ-010 A misaligned target SHALL leave pc_current unchanged, load trap_pc with the unmodified target, set misalign_trap and go to TRAP.
REQ-011 In TRAP, misalign_trap SHALL stay 1 until trap_ack; trap_ack SHALL load pc_current with TRAP_VECTOR, clear misalign_trap and go to FETCH.
REQ-012 redirect_valid SHALL have priority over fetch_ready, update_pc and trap_ack in every state:
- pc_current loads redirect_addr with its low bits forced to 0 (2 bits when ALIGN_C=0, 1 bit when ALIGN_C=1).
- misalign_trap clears.
- The FSM goes to FETCH.
- No trap is raised.
REQ-013 A redirect during FETCH SHALL abandon the pending fetch, with fetch_addr changing the following cycle.
REQ-014 taken_count SHALL increment by 1 for each accepted aligned update_pc whose target is not pc+4 by jump_type selection.
- The count wraps from 2^CNT_WIDTH-1 to 0.
- The count is not incremented by traps or redirects.
REQ-015 pc_plus_4 SHALL be combinational from pc_current and SHALL wrap at 2^DATA_WIDTH.
REQ-016 trap_pc SHALL hold its last value until the next trap.

Reset
REQ-017 While rst_n=0, the outputs SHALL take these values: pc_current=RESET_VECTOR, state=FETCH, fetch_valid=0, misalign_trap=0, trap_pc=0 and taken_count=0.
REQ-018 Assertion of rst_n SHALL take effect immediately, regardless of clk, and SHALL abort any state, including TRAP.
REQ-019 fetch_valid SHALL rise on the first clk edge after rst_n deasserts.

Verification
REQ-020 Reset then fetch_ready=1 for one cycle, then update_pc with jump_type=none -> fetch_addr 0x0, then fetch_addr 0x4, taken_count=0.
REQ-021 With pc=0x10, `JUMP_IF_1 with alu_result=1 and addr_offset=0xFFFF_FFF8 -> pc=0x08, taken_count=1; the same case with alu_result=0 -> pc=0x14.
REQ-022 With ALIGN_C=0 and pc=0x20, `JUMP_JALR with alu_result=0x103 -> misalign_trap=1, trap_pc=0x102, pc stays 0x20; then trap_ack -> pc=0x100, fetch_valid=1 next cycle.
REQ-023 With ALIGN_C=1, the same JALR -> pc=0x102 with no trap.
REQ-024 In TRAP, redirect_valid and trap_ack together with redirect_addr=0x207 -> pc=0x204, misalign_trap=0; also hold fetch_ready=0 for 5 cycles -> fetch_addr stable, with update_pc ignored.
REQ-025 Preload taken_count to all ones (CNT_WIDTH=4, 15 jumps), then one more JAL -> taken_count=0; assert rst_n=0 mid-EXEC -> pc=RESET_VECTOR at once, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer: PC sequencer with a fetch/exec/trap FSM, misalignment trap,
//               external redirect and a retired taken-jump counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int                    ALIGN_C      = 0,
  parameter int                    CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  update_pc,
  input  logic [2:0]            jump_type,
  input  logic [DATA_WIDTH-1:0] addr_offset,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_addr,
  input  logic                  fetch_ready,
  input  logic                  trap_ack,
  output logic [DATA_WIDTH-1:0] pc_current,
  output logic [DATA_WIDTH-1:0] pc_plus_4,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_addr,
  output logic                  misalign_trap,
  output logic [DATA_WIDTH-1:0] trap_pc,
  output logic [CNT_WIDTH-1:0]  taken_count
);

  // Jump encodings; every other jump_type value is a sequential step.
  localparam logic [2:0] JUMP_JAL  = 3'd1;
  localparam logic [2:0] JUMP_JALR = 3'd2;
  localparam logic [2:0] JUMP_IF_0 = 3'd3;
  localparam logic [2:0] JUMP_IF_1 = 3'd4;
  localparam logic [2:0] JUMP_ZERO = 3'd5;

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = (ALIGN_C == 0) ?
      {{(DATA_WIDTH-2){1'b1}}, 2'b00} : {{(DATA_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    TRAP  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  fetch_valid_q, fetch_valid_d;
  logic                  trap_q, trap_d;
  logic [DATA_WIDTH-1:0] trap_pc_q, trap_pc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] target;
  logic                  jump_sel;
  logic                  misaligned;

  assign pc_plus_4 = pc_q + DATA_WIDTH'(4);

  always_comb begin
    target   = pc_plus_4;
    jump_sel = 1'b0;
    case (jump_type)
      JUMP_JAL: begin
        target   = pc_q + addr_offset;
        jump_sel = 1'b1;
      end
      JUMP_JALR: begin
        target   = {alu_result[DATA_WIDTH-1:1], 1'b0};
        jump_sel = 1'b1;
      end
      JUMP_IF_0: begin
        if (!alu_result[0]) begin
          target   = pc_q + addr_offset;
          jump_sel = 1'b1;
        end
      end
      JUMP_IF_1: begin
        if (alu_result[0]) begin
          target   = pc_q + addr_offset;
          jump_sel = 1'b1;
        end
      end
      JUMP_ZERO: begin
        target   = '0;
        jump_sel = 1'b1;
      end
      default: ;
    endcase
    misaligned = (ALIGN_C == 0) ? (target[1:0] != 2'b00) : target[0];
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    trap_d    = trap_q;
    trap_pc_d = trap_pc_q;
    cnt_d     = cnt_q;
    // Redirect overrides every handshake in every state.
    if (redirect_valid) begin
      pc_d    = redirect_addr & ALIGN_MASK;
      trap_d  = 1'b0;
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (fetch_valid_q && fetch_ready) state_d = EXEC;
        end
        EXEC: begin
          if (update_pc) begin
            if (misaligned) begin
              trap_pc_d = target;
              trap_d    = 1'b1;
              state_d   = TRAP;
            end else begin
              pc_d    = target;
              state_d = FETCH;
              if (jump_sel) cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        TRAP: begin
          if (trap_ack) begin
            pc_d    = TRAP_VECTOR;
            trap_d  = 1'b0;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
    // Registered so the request stays low while held in reset.
    fetch_valid_d = (state_d == FETCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      trap_q        <= 1'b0;
      trap_pc_q     <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      trap_q        <= trap_d;
      trap_pc_q     <= trap_pc_d;
      cnt_q         <= cnt_d;
    end
  end

  assign pc_current    = pc_q;
  assign fetch_addr    = pc_q;
  assign fetch_valid   = fetch_valid_q;
  assign misalign_trap = trap_q;
  assign trap_pc       = trap_pc_q;
  assign taken_count   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer (4-byte and
//                  2-byte alignment instances, 4-bit taken counter).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  localparam logic [2:0] J_NONE = 3'd0;
  localparam logic [2:0] J_JAL  = 3'd1;
  localparam logic [2:0] J_JALR = 3'd2;
  localparam logic [2:0] J_IF0  = 3'd3;
  localparam logic [2:0] J_IF1  = 3'd4;
  localparam logic [2:0] J_ZERO = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n, rst_n2;
  logic        update_pc, redirect_valid, fetch_ready, trap_ack;
  logic [2:0]  jump_type;
  logic [31:0] addr_offset, alu_result, redirect_addr;

  logic [31:0] pc0, pp0, fa0, tp0, pc1, pp1, fa1, tp1;
  logic        fv0, tr0, fv1, tr1;
  logic [3:0]  cnt0, cnt1;

  logic        sel;
  logic [31:0] o_pc, o_pp, o_fa, o_tp;
  logic        o_fv, o_tr;
  logic [3:0]  o_cnt;

  assign o_pc  = sel ? pc1  : pc0;
  assign o_pp  = sel ? pp1  : pp0;
  assign o_fa  = sel ? fa1  : fa0;
  assign o_tp  = sel ? tp1  : tp0;
  assign o_fv  = sel ? fv1  : fv0;
  assign o_tr  = sel ? tr1  : tr0;
  assign o_cnt = sel ? cnt1 : cnt0;

  pc_sequencer #(.DATA_WIDTH(32), .ALIGN_C(0), .CNT_WIDTH(4)) u_dut_a4 (
    .clk(clk), .rst_n(rst_n), .update_pc(update_pc), .jump_type(jump_type),
    .addr_offset(addr_offset), .alu_result(alu_result),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .fetch_ready(fetch_ready), .trap_ack(trap_ack),
    .pc_current(pc0), .pc_plus_4(pp0), .fetch_valid(fv0), .fetch_addr(fa0),
    .misalign_trap(tr0), .trap_pc(tp0), .taken_count(cnt0)
  );

  pc_sequencer #(.DATA_WIDTH(32), .ALIGN_C(1), .CNT_WIDTH(4)) u_dut_a2 (
    .clk(clk), .rst_n(rst_n2), .update_pc(update_pc), .jump_type(jump_type),
    .addr_offset(addr_offset), .alu_result(alu_result),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .fetch_ready(fetch_ready), .trap_ack(trap_ack),
    .pc_current(pc1), .pc_plus_4(pp1), .fetch_valid(fv1), .fetch_addr(fa1),
    .misalign_trap(tr1), .trap_pc(tp1), .taken_count(cnt1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  cnt;
    logic        trap;
    logic [31:0] tpc;
    logic        fv;
  } exp_t;

  exp_t  sb[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  logic [31:0] exp_pc;
  logic [3:0]  exp_cnt;
  logic        exp_trap;
  logic [31:0] exp_tpc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_now(string tag, logic fv);
    exp_t e;
    e.pc   = exp_pc;
    e.cnt  = exp_cnt;
    e.trap = exp_trap;
    e.tpc  = exp_tpc;
    e.fv   = fv;
    sb.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare_next();
    exp_t  e;
    string t;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard: observed empty queue required an entry");
      return;
    end
    e = sb.pop_front();
    t = tag_q.pop_front();
    check({t, ".pc"},   o_pc,          e.pc);
    check({t, ".fa"},   o_fa,          e.pc);
    check({t, ".pp4"},  o_pp,          e.pc + 32'd4);
    check({t, ".cnt"},  {28'd0, o_cnt}, {28'd0, e.cnt});
    check({t, ".trap"}, {31'd0, o_tr},  {31'd0, e.trap});
    check({t, ".tpc"},  o_tp,          e.tpc);
    check({t, ".fv"},   {31'd0, o_fv},  {31'd0, e.fv});
  endtask

  task automatic step_fetch(string tag);
    fetch_ready = 1'b1;
    expect_now(tag, 1'b0);
    tick();
    fetch_ready = 1'b0;
    compare_next();
  endtask

  task automatic step_update(string tag, logic [2:0] jt, logic [31:0] off,
                             logic [31:0] alu, logic [31:0] tgt,
                             logic trap, logic taken);
    jump_type   = jt;
    addr_offset = off;
    alu_result  = alu;
    update_pc   = 1'b1;
    if (trap) begin
      exp_trap = 1'b1;
      exp_tpc  = tgt;
    end else begin
      exp_pc = tgt;
      if (taken) exp_cnt = exp_cnt + 4'd1;
    end
    expect_now(tag, !trap);
    tick();
    update_pc = 1'b0;
    compare_next();
  endtask

  task automatic step_redirect(string tag, logic [31:0] addr, logic [31:0] new_pc);
    redirect_valid = 1'b1;
    redirect_addr  = addr;
    exp_pc         = new_pc;
    exp_trap       = 1'b0;
    expect_now(tag, 1'b1);
    tick();
    redirect_valid = 1'b0;
    compare_next();
  endtask

  task automatic step_trap_ack(string tag);
    trap_ack = 1'b1;
    exp_pc   = 32'h100;
    exp_trap = 1'b0;
    expect_now(tag, 1'b1);
    tick();
    trap_ack = 1'b0;
    compare_next();
  endtask

  initial begin
    sel = 1'b0;
    rst_n = 1'b0; rst_n2 = 1'b0;
    update_pc = 1'b0; redirect_valid = 1'b0; fetch_ready = 1'b0; trap_ack = 1'b0;
    jump_type = J_NONE; addr_offset = '0; alu_result = '0; redirect_addr = '0;
    exp_pc = 32'h0; exp_cnt = 4'd0; exp_trap = 1'b0; exp_tpc = 32'h0;

    // Reset values while rst_n is low.
    #3;
    expect_now("reset", 1'b0);
    compare_next();
    #9 rst_n = 1'b1;
    expect_now("rst_release", 1'b1);
    tick();
    compare_next();

    step_fetch("fetch0");
    step_update("seq_none", J_NONE, 32'h0, 32'h0, 32'h4, 1'b0, 1'b0);

    step_redirect("redir_10a", 32'h10, 32'h10);
    step_fetch("fetch_10a");
    step_update("if1_taken", J_IF1, 32'hFFFF_FFF8, 32'h1, 32'h08, 1'b0, 1'b1);

    step_redirect("redir_10b", 32'h10, 32'h10);
    step_fetch("fetch_10b");
    step_update("if1_not", J_IF1, 32'hFFFF_FFF8, 32'h0, 32'h14, 1'b0, 1'b0);

    step_fetch("fetch_14");
    step_update("if0_taken", J_IF0, 32'h10, 32'h0, 32'h24, 1'b0, 1'b1);
    step_fetch("fetch_24");
    step_update("if0_not", J_IF0, 32'h10, 32'h1, 32'h28, 1'b0, 1'b0);
    step_fetch("fetch_28");
    step_update("jal", J_JAL, 32'h40, 32'h0, 32'h68, 1'b0, 1'b1);
    step_fetch("fetch_68");
    step_update("jzero", J_ZERO, 32'h40, 32'h0, 32'h0, 1'b0, 1'b1);
    step_fetch("fetch_0");
    step_update("jt_unknown", 3'd7, 32'h40, 32'h0, 32'h4, 1'b0, 1'b0);

    step_redirect("redir_wrap", 32'hFFFF_FFFE, 32'hFFFF_FFFC);

    // Misaligned JALR traps with pc held, then trap_ack vectors away.
    step_redirect("redir_20", 32'h20, 32'h20);
    step_fetch("fetch_20");
    step_update("jalr_mis", J_JALR, 32'h0, 32'h103, 32'h102, 1'b1, 1'b0);
    jump_type = J_JAL; addr_offset = 32'h40; update_pc = 1'b1;
    expect_now("trap_ignore_upd", 1'b0);
    tick();
    update_pc = 1'b0;
    compare_next();
    step_trap_ack("trap_ack");

    step_fetch("fetch_100");
    step_update("jal_mis", J_JAL, 32'h6, 32'h0, 32'h106, 1'b1, 1'b0);

    // Redirect beats trap_ack in TRAP.
    trap_ack = 1'b1;
    step_redirect("redir_vs_ack", 32'h207, 32'h204);
    trap_ack = 1'b0;

    // Fetch stalled: address stable and update_pc ignored.
    update_pc = 1'b1; jump_type = J_JAL; addr_offset = 32'h40;
    for (int i = 0; i < 5; i++) begin
      expect_now("fetch_stall", 1'b1);
      tick();
      compare_next();
    end
    update_pc = 1'b0;

    // Drive the counter to all ones, then one more jump wraps it.
    for (int i = 0; i < 16 && exp_cnt != 4'hF; i++) begin
      step_fetch("fetch_cnt");
      step_update("jal_cnt", J_JAL, 32'h8, 32'h0, exp_pc + 32'h8, 1'b0, 1'b1);
    end
    step_fetch("fetch_wrap");
    step_update("cnt_wrap", J_JAL, 32'h8, 32'h0, exp_pc + 32'h8, 1'b0, 1'b1);

    // Asynchronous reset mid-EXEC, no clock edge in between.
    step_fetch("fetch_pre_rst");
    #2 rst_n = 1'b0;
    #1;
    exp_pc = 32'h0; exp_cnt = 4'd0; exp_trap = 1'b0; exp_tpc = 32'h0;
    expect_now("async_rst", 1'b0);
    compare_next();

    // Two-byte alignment instance.
    sel = 1'b1;
    rst_n2 = 1'b1;
    expect_now("a2_release", 1'b1);
    tick();
    compare_next();
    step_redirect("a2_redir_207", 32'h207, 32'h206);
    step_redirect("a2_redir_20", 32'h20, 32'h20);
    step_fetch("a2_fetch_20");
    step_update("a2_jalr", J_JALR, 32'h0, 32'h103, 32'h102, 1'b0, 1'b1);
    step_fetch("a2_fetch_102");
    step_update("a2_jal_mis", J_JAL, 32'h1, 32'h0, 32'h103, 1'b1, 1'b0);
    step_trap_ack("a2_trap_ack");
    step_fetch("a2_fetch_100");
    step_update("a2_jal_half", J_JAL, 32'h2, 32'h0, 32'h102, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
